qdi2bin_rx_fifo_e1of2: RTL and testbench
========================================

Name: qdi2bin_rx_fifo_e1of2

Overview:
- Clocked, parametrised receiver that accepts a WIDTH-bit word from a QDI circuit on WIDTH e1of2 dual-rail pairs with a single shared Le enable.
- Decodes each word to binary and buffers it in a DEPTH-entry first-word-fall-through FIFO drained by a valid/ready consumer.
- rxe gating, FIFO backpressure and sticky code-error detection are included.
- Sits on the boundary between QDI datapaths and the Verilog testbench/checker logic; used for throughput-vs-tokens and multi-bit channel measurements.

Parameters:
WIDTH, 8, number of e1of2 rail pairs (data bits per word), >=1
DEPTH, 4, FIFO entries, >=2, need not be a power of two
LE_DLY, 0, extra CLK cycles inserted before every Le transition (models backward latency)

Ports:
CLK  input  1  sampling/consumer clock, rising edge
RESET  input  1  reset, asynchronous, active-low
L  input  2*WIDTH  dual-rail data; pair i = L[2i+1:2i]
Le  output  1  left enable to QDI circuit; low = word acknowledged
rxe  input  1  receive enable; must be high for a word to be captured
dout  output  WIDTH  FIFO head word
valid  output  1  FIFO non-empty
ready  input  1  consumer accepts head when valid && ready
count  output  $clog2(DEPTH+1)  current FIFO occupancy
err  output  1  sticky: an invalid rail code was captured
VDD, GND  inout  1  supply pins, unused by logic

Behaviour:
- Pair decode: 01 -> 0, 10 -> 1, 00 -> neutral, 11 -> invalid.
- Signal definitions:
  - all_valid = every pair non-00.
  - all_neutral = every pair 00.
  - full = (count == DEPTH), evaluated on the pre-edge count.
- Reset, asynchronous on RESET low:
  - Le=0 (circuit held in reset), valid=0, dout=0, count=0, err=0.
  - FIFO pointers = 0, FSM = IDLE, delay counter = 0.
  - On release, Le rises at the first CLK edge after RESET is high.
  - A reset mid-handshake discards the word in flight and flushes the FIFO.
- FSM states:
  - IDLE (Le=1): when all_valid && rxe && !full, capture the decoded word, push it, go to ACK_WAIT.
  - IDLE, partial validity, rxe=0 or full: hold IDLE with Le=1. This is the backpressure; no timeout.
  - ACK_WAIT: count LE_DLY cycles, then drive Le=0 and go to NEUTRAL_WAIT. With LE_DLY=0, Le falls on the same edge as the push.
  - NEUTRAL_WAIT (Le=0): wait for all_neutral, count LE_DLY cycles, drive Le=1, go to IDLE.
  - NEUTRAL_WAIT, partially neutral rails: keep waiting.
- Latency (LE_DLY=0): all_valid sampled at edge k -> Le=0, valid=1, dout=word after edge k. all_neutral sampled at edge k -> Le=1 after edge k.
  - Minimum 2 CLK cycles per token.
- Invalid pair (11) at capture:
  - That bit is stored as 0 and err sets.
  - err clears only by reset.
  - The handshake completes normally.
- FIFO:
  - Pop when valid && ready; dout updates to the next entry on the same edge.
  - Push and pop on the same edge with count in 1..DEPTH-1: count unchanged, order preserved.
  - Full: no push, even if a pop occurs the same edge; the capture retries next cycle.
  - Pointers wrap modulo DEPTH.
  - ready while empty: no effect.
- dout holds its last value when the FIFO is empty. Checkers qualify dout with valid.

Optional Feature:
- Macro: QDI2BIN_SYNC_EN.
- Defined:
  - L and rxe each pass through a 2-flop synchroniser before decode.
  - All L-to-Le and L-to-valid latencies increase by 2 CLK cycles.
  - Synchroniser flops reset to 0.
- Undefined: L and rxe are sampled directly, with the latencies given above.

Test Plan:
- Reset then single token, WIDTH=8, LE_DLY=0, ready=1: drive L encoding 0xA5 -> Le=1 after release; Le=0 and valid=1, dout=0xA5 one edge after all_valid; L neutral -> Le=1 next edge.
- Backpressure, DEPTH=4, ready=0: send 5 words 0x01..0x05 -> count reaches 4, Le stays 1 on the 5th word. Assert ready -> pops 0x01..0x04 in order, then the 5th word is captured and popped last.
- rxe gating: all_valid with rxe=0 for 10 cycles -> Le stays 1, count=0. Raise rxe -> capture on the next edge.
- Invalid code: pair 3 = 11, others encode 0 -> word 0x00 pushed, err=1. Next valid token 0xFF -> err remains 1.
- Reset mid-handshake: assert RESET in NEUTRAL_WAIT with count=2 -> Le=0 and valid=0 immediately, count=0. After release, Le=1 at the next edge.
- LE_DLY=3: measure edges from all_valid to Le fall and from all_neutral to Le rise -> 3 each beyond the LE_DLY=0 timing. Repeat with QDI2BIN_SYNC_EN defined -> +2 additional cycles on each.

Source files
------------

// File: rtl/qdi2bin_rx_fifo_e1of2_if.sv
// Word-level bus between the QDI receiver and its consumer.
// slave = the receiver; master = the QDI source / consumer side.
interface qdi2bin_rx_fifo_e1of2_if #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
);
    localparam int CW = $clog2(DEPTH + 1);

    logic [2*WIDTH-1:0] L;
    logic               Le;
    logic               rxe;
    logic [WIDTH-1:0]   dout;
    logic               valid;
    logic               ready;
    logic [CW-1:0]      count;
    logic               err;

    modport slave (
        input  L, rxe, ready,
        output Le, dout, valid, count, err
    );

    modport master (
        output L, rxe, ready,
        input  Le, dout, valid, count, err
    );
endinterface

// File: rtl/qdi2bin_rx_fifo_e1of2.sv
// e1of2 dual-rail QDI word receiver feeding a first-word-fall-through FIFO.
// Define QDI2BIN_SYNC_EN to pass L and rxe through 2-flop synchronisers.
module qdi2bin_rx_fifo_e1of2 #(
    parameter int WIDTH  = 8,
    parameter int DEPTH  = 4,
    parameter int LE_DLY = 0
) (
    input  logic CLK,
    input  logic RESET,
    inout  wire  VDD,
    inout  wire  GND,
    qdi2bin_rx_fifo_e1of2_if.slave rx
);

    localparam int          CW       = $clog2(DEPTH + 1);
    localparam int          PW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int          DW       = (LE_DLY > 1) ? $clog2(LE_DLY) : 1;
    localparam int unsigned DLY_LAST = (LE_DLY > 0) ? LE_DLY - 1 : 0;

    typedef enum logic [1:0] {
        IDLE,
        ACK_WAIT,
        NEUTRAL_WAIT,
        REL_DLY
    } state_t;

    logic [2*WIDTH-1:0] l_in;
    logic               rxe_in;

    logic               all_valid;
    logic               all_neutral;
    logic               any_bad;
    logic [WIDTH-1:0]   word;
    logic [1:0]         pair;

    state_t             state_q, state_d;
    logic               le_q, le_d;
    logic [DW-1:0]      dly_q, dly_d;
    logic               dly_last;
    logic               push;

    logic [WIDTH-1:0]   mem_q [DEPTH];
    logic [WIDTH-1:0]   mem_d [DEPTH];
    logic [PW-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]      rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]      rd_next;
    logic [CW-1:0]      count_q, count_d;
    logic [WIDTH-1:0]   dout_q, dout_d;
    logic               err_q, err_d;
    logic               valid;
    logic               full;
    logic               pop;

    logic               unused_supply;
    assign unused_supply = ^{VDD, GND};

`ifdef QDI2BIN_SYNC_EN
    logic [2*WIDTH-1:0] l_meta_q, l_sync_q;
    logic               rxe_meta_q, rxe_sync_q;

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            l_meta_q   <= '0;
            l_sync_q   <= '0;
            rxe_meta_q <= 1'b0;
            rxe_sync_q <= 1'b0;
        end else begin
            l_meta_q   <= rx.L;
            l_sync_q   <= l_meta_q;
            rxe_meta_q <= rx.rxe;
            rxe_sync_q <= rxe_meta_q;
        end
    end

    assign l_in   = l_sync_q;
    assign rxe_in = rxe_sync_q;
`else
    assign l_in   = rx.L;
    assign rxe_in = rx.rxe;
`endif

    // 01 -> 0, 10 -> 1, 00 -> neutral, 11 -> invalid (stored as 0)
    always_comb begin
        all_valid   = 1'b1;
        all_neutral = 1'b1;
        any_bad     = 1'b0;
        word        = '0;
        pair        = 2'b00;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            pair = l_in[2*i +: 2];
            if (pair == 2'b00) begin
                all_valid = 1'b0;
            end else begin
                all_neutral = 1'b0;
            end
            if (pair == 2'b10) begin
                word[i] = 1'b1;
            end
            if (pair == 2'b11) begin
                any_bad = 1'b1;
            end
        end
    end

    assign valid    = (count_q != '0);
    assign full     = (count_q == CW'(DEPTH));
    assign pop      = valid && rx.ready;
    assign dly_last = (dly_q == DW'(DLY_LAST));

    // Le is held low through reset, so IDLE first raises it before any capture.
    always_comb begin
        state_d = state_q;
        le_d    = le_q;
        dly_d   = dly_q;
        push    = 1'b0;
        case (state_q)
            IDLE: begin
                if (!le_q) begin
                    le_d = 1'b1;
                end else if (all_valid && rxe_in && !full) begin
                    push = 1'b1;
                    if (LE_DLY == 0) begin
                        le_d    = 1'b0;
                        state_d = NEUTRAL_WAIT;
                    end else begin
                        dly_d   = '0;
                        state_d = ACK_WAIT;
                    end
                end
            end
            ACK_WAIT: begin
                if (dly_last) begin
                    le_d    = 1'b0;
                    dly_d   = '0;
                    state_d = NEUTRAL_WAIT;
                end else begin
                    dly_d = dly_q + 1'b1;
                end
            end
            NEUTRAL_WAIT: begin
                if (all_neutral) begin
                    if (LE_DLY == 0) begin
                        le_d    = 1'b1;
                        state_d = IDLE;
                    end else begin
                        dly_d   = '0;
                        state_d = REL_DLY;
                    end
                end
            end
            REL_DLY: begin
                if (dly_last) begin
                    le_d    = 1'b1;
                    dly_d   = '0;
                    state_d = IDLE;
                end else begin
                    dly_d = dly_q + 1'b1;
                end
            end
            default: begin
                le_d    = 1'b0;
                dly_d   = '0;
                state_d = IDLE;
            end
        endcase
    end

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign rd_next = ptr_inc(rd_ptr_q);

    // dout is a registered head copy: a push into an empty (or emptying)
    // FIFO loads it directly, otherwise a pop loads the following entry.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        dout_d   = dout_q;
        err_d    = err_q;

        if (push) begin
            mem_d[wr_ptr_q] = word;
            wr_ptr_d        = ptr_inc(wr_ptr_q);
            err_d           = err_q | any_bad;
        end
        if (pop) begin
            rd_ptr_d = rd_next;
        end

        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase

        if (push && (!valid || (pop && count_q == CW'(1)))) begin
            dout_d = word;
        end else if (pop && count_q > CW'(1)) begin
            dout_d = mem_q[rd_next];
        end
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q  <= IDLE;
            le_q     <= 1'b0;
            dly_q    <= '0;
            mem_q    <= '{default: '0};
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            dout_q   <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            le_q     <= le_d;
            dly_q    <= dly_d;
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            dout_q   <= dout_d;
            err_q    <= err_d;
        end
    end

    assign rx.Le    = le_q;
    assign rx.dout  = dout_q;
    assign rx.valid = valid;
    assign rx.count = count_q;
    assign rx.err   = err_q;

endmodule

// File: tb/tb_qdi2bin_rx_fifo_e1of2.sv
// Directed bench: vector table for the FIFO/handshake, hand sequences for
// rxe gating, mid-handshake reset and LE_DLY/synchroniser latency.
module tb_qdi2bin_rx_fifo_e1of2;

`ifdef QDI2BIN_SYNC_EN
    localparam int SYNC_LAT = 2;
`else
    localparam int SYNC_LAT = 0;
`endif

    logic clk = 1'b0;
    logic rst_n;
    wire  vdd;
    wire  gnd;
    assign vdd = 1'b1;
    assign gnd = 1'b0;

    always #5 clk = ~clk;

    qdi2bin_rx_fifo_e1of2_if #(.WIDTH(8), .DEPTH(4)) if0 ();
    qdi2bin_rx_fifo_e1of2_if #(.WIDTH(8), .DEPTH(4)) if1 ();

    qdi2bin_rx_fifo_e1of2 #(.WIDTH(8), .DEPTH(4), .LE_DLY(0)) dut0 (
        .CLK(clk), .RESET(rst_n), .VDD(vdd), .GND(gnd), .rx(if0)
    );

    qdi2bin_rx_fifo_e1of2 #(.WIDTH(8), .DEPTH(4), .LE_DLY(3)) dut1 (
        .CLK(clk), .RESET(rst_n), .VDD(vdd), .GND(gnd), .rx(if1)
    );

    typedef struct {
        logic [15:0] l;
        logic        rxe;
        logic        ready;
        logic        le;
        logic        valid;
        logic [7:0]  dout;
        logic [2:0]  count;
        logic        err;
    } vec_t;

    vec_t tbl[$];
    int   total = 0;
    int   bad   = 0;

    function automatic logic [15:0] enc(input logic [7:0] b);
        logic [15:0] r;
        for (int i = 0; i < 8; i++) r[2*i +: 2] = b[i] ? 2'b10 : 2'b01;
        return r;
    endfunction

    function automatic vec_t mk(input logic [15:0] l, input logic rxe, input logic ready,
                                input logic le, input logic valid, input logic [7:0] dout,
                                input logic [2:0] count, input logic err);
        vec_t v;
        v.l = l; v.rxe = rxe; v.ready = ready;
        v.le = le; v.valid = valid; v.dout = dout; v.count = count; v.err = err;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Inputs change at a negedge; ready is only offered on the edge where the
    // (possibly synchronised) rails take effect, so one vector = one token step.
    task automatic apply_vec(input int idx, input vec_t v);
        if0.L   = v.l;
        if0.rxe = v.rxe;
        for (int k = 0; k < SYNC_LAT; k++) begin
            if0.ready = 1'b0;
            @(negedge clk);
        end
        if0.ready = v.ready;
        @(negedge clk);
        chk($sformatf("v%0d.Le", idx),    32'(if0.Le),    32'(v.le));
        chk($sformatf("v%0d.valid", idx), 32'(if0.valid), 32'(v.valid));
        chk($sformatf("v%0d.dout", idx),  32'(if0.dout),  32'(v.dout));
        chk($sformatf("v%0d.count", idx), 32'(if0.count), 32'(v.count));
        chk($sformatf("v%0d.err", idx),   32'(if0.err),   32'(v.err));
    endtask

    // sel: 0 = dut0 Le, 1 = dut1 Le, 2 = dut1 valid; n = edges until target, -1 on timeout
    task automatic measure(input int sel, input logic target, output int n);
        logic s;
        n = -1;
        for (int k = 1; k <= 30; k++) begin
            @(posedge clk);
            #1;
            s = (sel == 0) ? if0.Le : (sel == 1) ? if1.Le : if1.valid;
            if (s === target) begin
                n = k;
                break;
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n;

        rst_n = 1'b0;
        if0.L = '0; if0.rxe = 1'b0; if0.ready = 1'b0;
        if1.L = '0; if1.rxe = 1'b0; if1.ready = 1'b1;

        tbl.push_back(mk(enc(8'hA5),            1, 0, 0, 1, 8'hA5, 1, 0));
        tbl.push_back(mk(16'h0000,              1, 0, 1, 1, 8'hA5, 1, 0));
        tbl.push_back(mk(enc(8'h01),            1, 0, 0, 1, 8'hA5, 2, 0));
        tbl.push_back(mk(16'h0000,              1, 0, 1, 1, 8'hA5, 2, 0));
        tbl.push_back(mk(enc(8'h02),            1, 0, 0, 1, 8'hA5, 3, 0));
        tbl.push_back(mk(16'h0000,              1, 0, 1, 1, 8'hA5, 3, 0));
        tbl.push_back(mk(enc(8'h03),            1, 0, 0, 1, 8'hA5, 4, 0));
        tbl.push_back(mk(16'h0000,              1, 0, 1, 1, 8'hA5, 4, 0));
        tbl.push_back(mk(enc(8'h04),            1, 0, 1, 1, 8'hA5, 4, 0));
        tbl.push_back(mk(enc(8'h04),            1, 1, 1, 1, 8'h01, 3, 0));
        tbl.push_back(mk(enc(8'h04),            1, 0, 0, 1, 8'h01, 4, 0));
        tbl.push_back(mk(16'h0000,              1, 1, 1, 1, 8'h02, 3, 0));
        tbl.push_back(mk(16'h0000,              1, 1, 1, 1, 8'h03, 2, 0));
        tbl.push_back(mk(enc(8'h05),            1, 1, 0, 1, 8'h04, 2, 0));
        tbl.push_back(mk(16'h0000,              1, 1, 1, 1, 8'h05, 1, 0));
        tbl.push_back(mk(16'h0000,              1, 1, 1, 0, 8'h05, 0, 0));
        tbl.push_back(mk(16'h0000,              1, 1, 1, 0, 8'h05, 0, 0));
        tbl.push_back(mk(16'h55D5,              1, 0, 0, 1, 8'h00, 1, 1));
        tbl.push_back(mk(16'h0000,              1, 0, 1, 1, 8'h00, 1, 1));
        tbl.push_back(mk(enc(8'hFF),            1, 1, 0, 1, 8'hFF, 1, 1));
        tbl.push_back(mk(16'h0000,              1, 1, 1, 0, 8'hFF, 0, 1));
        tbl.push_back(mk(enc(8'h3C) & ~16'h0003, 1, 0, 1, 0, 8'hFF, 0, 1));
        tbl.push_back(mk(enc(8'h3C),            1, 0, 0, 1, 8'h3C, 1, 1));
        tbl.push_back(mk(enc(8'h3C) & 16'h0C00, 1, 0, 0, 1, 8'h3C, 1, 1));
        tbl.push_back(mk(16'h0000,              1, 0, 1, 1, 8'h3C, 1, 1));
        tbl.push_back(mk(16'h0000,              1, 1, 1, 0, 8'h3C, 0, 1));

        repeat (2) @(negedge clk);
        chk("rst.Le",    32'(if0.Le),    32'd0);
        chk("rst.valid", 32'(if0.valid), 32'd0);
        chk("rst.dout",  32'(if0.dout),  32'd0);
        chk("rst.count", 32'(if0.count), 32'd0);
        chk("rst.err",   32'(if0.err),   32'd0);
        chk("rst.Le1",   32'(if1.Le),    32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("release.Le",  32'(if0.Le), 32'd1);
        chk("release.Le1", 32'(if1.Le), 32'd1);

        foreach (tbl[i]) apply_vec(i, tbl[i]);

        // rxe gating: a complete word is ignored while rxe is low
        if0.L = enc(8'h5A); if0.rxe = 1'b0; if0.ready = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            chk($sformatf("rxe_off%0d.Le", c),    32'(if0.Le),    32'd1);
            chk($sformatf("rxe_off%0d.count", c), 32'(if0.count), 32'd0);
        end
        if0.rxe = 1'b1;
        repeat (1 + SYNC_LAT) @(negedge clk);
        chk("rxe_on.Le",    32'(if0.Le),    32'd0);
        chk("rxe_on.count", 32'(if0.count), 32'd1);
        chk("rxe_on.dout",  32'(if0.dout),  32'h5A);
        if0.L = '0;
        repeat (1 + SYNC_LAT) @(negedge clk);
        chk("rxe_neutral.Le", 32'(if0.Le), 32'd1);
        if0.ready = 1'b1;
        @(negedge clk);
        if0.ready = 1'b0;
        chk("rxe_pop.count", 32'(if0.count), 32'd0);

        // reset while waiting for neutral with two words buffered
        apply_vec(100, mk(enc(8'h11), 1, 0, 0, 1, 8'h11, 1, 1));
        apply_vec(101, mk(16'h0000,   1, 0, 1, 1, 8'h11, 1, 1));
        apply_vec(102, mk(enc(8'h22), 1, 0, 0, 1, 8'h11, 2, 1));
        #2 rst_n = 1'b0;
        #1;
        chk("midrst.Le",    32'(if0.Le),    32'd0);
        chk("midrst.valid", 32'(if0.valid), 32'd0);
        chk("midrst.count", 32'(if0.count), 32'd0);
        chk("midrst.err",   32'(if0.err),   32'd0);
        chk("midrst.dout",  32'(if0.dout),  32'd0);
        @(negedge clk);
        if0.L = '0;
        rst_n = 1'b1;
        @(negedge clk);
        chk("midrst_rel.Le",    32'(if0.Le),    32'd1);
        chk("midrst_rel.count", 32'(if0.count), 32'd0);
        chk("midrst_rel.Le1",   32'(if1.Le),    32'd1);

        // handshake latency, LE_DLY = 0
        if0.L = enc(8'h81); if0.rxe = 1'b1; if0.ready = 1'b1;
        measure(0, 1'b0, n);
        chk("lat0.fall", 32'(n), 32'(1 + SYNC_LAT));
        @(negedge clk);
        if0.L = '0;
        measure(0, 1'b1, n);
        chk("lat0.rise", 32'(n), 32'(1 + SYNC_LAT));

        // handshake latency, LE_DLY = 3: push is immediate, Le moves 3 edges later
        @(negedge clk);
        if1.L = enc(8'h81); if1.rxe = 1'b1;
        measure(2, 1'b1, n);
        chk("lat3.push", 32'(n), 32'(1 + SYNC_LAT));
        measure(1, 1'b0, n);
        chk("lat3.fall_after_push", 32'(n), 32'd3);
        @(negedge clk);
        if1.L = '0;
        measure(1, 1'b1, n);
        chk("lat3.rise", 32'(n), 32'(4 + SYNC_LAT));
        @(negedge clk);
        chk("lat3.count", 32'(if1.count), 32'd0);
        chk("lat3.dout",  32'(if1.dout),  32'h81);
        chk("lat3.err",   32'(if1.err),   32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
